// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO and shifts it out
// as start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          par_en_q;
  logic          stop2_q;
  logic          par_bit;
  logic          stop_cnt;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_MAX);

  // FIFO handshake: a byte is available whenever fifo_empty is low; fifo_rd_en is a
  // one-cycle pop that the FIFO honours at the same edge that captures fifo_data.
  assign fifo_rd_en = (state == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit   <= 1'b0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      if (state != IDLE && state != LOAD) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_done <= 1'b0;
          if (tx_en && !fifo_empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shift_reg <= fifo_data;
          par_en_q  <= parity_en;
          stop2_q   <= stop2;
          par_bit   <= (^fifo_data) ^ parity_odd;
          baud_cnt  <= '0;
          bit_idx   <= '0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              stop_cnt <= 1'b0;
              if (par_en_q) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            // second stop bit only when two were latched at LOAD
            if (stop_cnt == stop2_q) begin
              state   <= IDLE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level model predicts every cycle's
// {tx, busy, tx_done, fifo_rd_en}; directed scenarios add hand-computed literal checks.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model, scoreboard and counters
  logic [7:0] fq[$];
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp;
  logic       load_now;
  logic       pop_pending;
  int         n_vec;
  int         n_miss;
  int         rd_count;
  logic       tx_log[0:255];
  int         cap_len;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh_fifo();
  endtask

  // One clock: advance the model at the edge, then compare the DUT #1 later.
  task automatic tick();
    logic [7:0] b;
    logic [3:0] act;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      load_now    = 1'b0;
      pop_pending = 1'b0;
    end else if (load_now) begin
      load_now = 1'b0;
      b = (fq.size() != 0) ? fq[0] : 8'h00;
      repeat (CPB) exp_q.push_back(4'b0100);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back({b[i], 3'b100});
      if (parity_en) repeat (CPB) exp_q.push_back({(^b) ^ parity_odd, 3'b100});
      repeat (stop2 ? 2 * CPB : CPB) exp_q.push_back(4'b1100);
      exp_q.push_back(4'b1010);
    end else if (exp_q.size() == 0 && tx_en && !fifo_empty) begin
      load_now = 1'b1;
    end
    if (load_now) cur_exp = 4'b1101;
    else if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
    else cur_exp = 4'b1000;
    #1;
    if (pop_pending && fq.size() != 0) begin
      void'(fq.pop_front());
      refresh_fifo();
    end
    act = {tx, busy, tx_done, fifo_rd_en};
    n_vec++;
    if (act !== cur_exp) begin
      n_miss++;
      $display("FAIL cycle_outputs {tx,busy,done,rd} got %b expected %b (t=%0t)", act, cur_exp, $time);
    end
    pop_pending = fifo_rd_en;
    if (fifo_rd_en) rd_count++;
  endtask

  task automatic wait_start();
    int guard = 0;
    while (tx !== 1'b0 && guard < 300) begin tick(); guard++; end
    if (tx !== 1'b0) check("start_bit_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (tx_done !== 1'b1 && guard < 300) begin tick(); guard++; end
    if (tx_done !== 1'b1) check("tx_done_timeout", 0, 1);
  endtask

  // Log tx from the current start-bit cycle until the tx_done cycle.
  task automatic record_frame();
    cap_len = 0;
    tx_log[0] = tx;
    while (tx_done !== 1'b1 && cap_len < 200) begin
      tick();
      cap_len++;
      tx_log[cap_len] = tx;
    end
    if (tx_done !== 1'b1) check("frame_end_timeout", 0, 1);
  endtask

  task automatic capture();
    wait_start();
    record_frame();
  endtask

  function automatic logic [7:0] frame_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx_log[CPB * (i + 1) + 1];
    return b;
  endfunction

  task automatic set_cfg(input logic pe, input logic po, input logic s2);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
  endtask

  initial begin
    int rd_base;
    int g;
    int lows;
    int highs;
    logic [9:0] bits;
    n_vec = 0; n_miss = 0; rd_count = 0;
    load_now = 1'b0; pop_pending = 1'b0; cur_exp = 4'b1000;
    rst_n = 1'b0; tx_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    refresh_fifo();
    repeat (3) tick();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_tx_done", tx_done, 0);
    rst_n = 1'b1;
    tx_en = 1'b1;
    repeat (2) tick();

    // 0xA5, no parity, one stop bit
    rd_base = rd_count;
    push(8'hA5);
    capture();
    for (int k = 0; k < 10; k++) bits[k] = tx_log[CPB * k + 1];
    check("a5_bits", bits, 10'b1101001010);
    check("a5_len", cap_len, 40);
    check("a5_pops", rd_count - rd_base, 1);

    // even parity then odd parity on 0x07
    set_cfg(1'b1, 1'b0, 1'b0);
    push(8'h07);
    capture();
    check("even_parity_bit", tx_log[CPB * 9 + 1], 1);
    check("even_parity_len", cap_len, 44);
    set_cfg(1'b1, 1'b1, 1'b0);
    push(8'h07);
    capture();
    check("odd_parity_bit", tx_log[CPB * 9 + 1], 0);
    check("odd_parity_len", cap_len, 44);

    // two stop bits on 0x00
    set_cfg(1'b0, 1'b0, 1'b1);
    push(8'h00);
    capture();
    lows = 0; highs = 0;
    for (int i = 0; i < cap_len; i++) if (tx_log[i] == 1'b0) lows++; else highs++;
    check("stop2_low_cycles", lows, 36);
    check("stop2_high_cycles", highs, 8);
    check("stop2_len", cap_len, 44);

    // back-to-back 0x55, 0x0F
    set_cfg(1'b0, 1'b0, 1'b0);
    rd_base = rd_count;
    push(8'h55);
    push(8'h0F);
    capture();
    check("b2b_first_byte", frame_byte(), 8'h55);
    g = 1;
    tick();
    while (tx === 1'b1 && g < 50) begin g++; tick(); end
    check("b2b_gap", g, 2);
    record_frame();
    check("b2b_second_byte", frame_byte(), 8'h0F);
    check("b2b_second_len", cap_len, 40);
    check("b2b_pops", rd_count - rd_base, 2);
    check("b2b_fifo_empty", fifo_empty, 1);

    // reset during DATA bit 3 of 0xFF, then 0x3C
    push(8'hFF);
    wait_start();
    repeat (CPB * 4 + 1) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    push(8'h3C);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_load_tx", tx, 1);
    tick();
    check("post_rst_start_tx", tx, 0);
    record_frame();
    check("post_rst_byte", frame_byte(), 8'h3C);
    check("post_rst_len", cap_len, 40);

    // tx_en low holds off a non-empty FIFO
    tx_en = 1'b0;
    rd_base = rd_count;
    push(8'h81);
    repeat (10) tick();
    check("txen_low_no_pop", rd_count - rd_base, 0);
    check("txen_low_tx_idle", tx, 1);
    tx_en = 1'b1;
    tick();
    check("txen_rise_load_tx", tx, 1);
    tick();
    check("txen_rise_start_tx", tx, 0);
    record_frame();
    check("txen_rise_byte", frame_byte(), 8'h81);

    // tx_en dropped mid-frame
    rd_base = rd_count;
    push(8'h33);
    wait_start();
    repeat (8) tick();
    tx_en = 1'b0;
    push(8'h44);
    wait_done();
    repeat (30) tick();
    check("txen_drop_pops", rd_count - rd_base, 1);
    check("txen_drop_idle_tx", tx, 1);
    check("txen_drop_idle_busy", busy, 0);
    tx_en = 1'b1;
    capture();
    check("txen_drop_next_byte", frame_byte(), 8'h44);

    // randomized traffic, config churn and tx_en toggling
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0 && fq.size() < 4) push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 29) == 0)
        set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    tx_en = 1'b1;
    g = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || load_now) && g < 3000) begin tick(); g++; end
    check("drain_fifo_empty", fifo_empty, 1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmit stage of the UART. Pops bytes from the transmit FIFO when data is present and tx_en is high. Shifts each byte out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from a fixed clocks-per-bit divider. Frame configuration arrives from the APB control register as level inputs.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range ≥ 2. The baud counter width is clog2(CLKS_PER_BIT).
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- tx_en  input  1  transmitter enable; when high, the block may start a new frame
- parity_en  input  1  when 1, a parity bit is appended after the data bits
- parity_odd  input  1  parity sense: 1 = odd, 0 = even
- stop2  input  1  when 1, two stop bits are sent; when 0, one stop bit
- fifo_empty  input  1  transmit FIFO empty flag
- fifo_data  input  8  FIFO head byte; valid one cycle after fifo_empty falls
- fifo_rd_en  output  1  single-cycle pop strobe to the FIFO
- tx  output  1  serial line; idle level is 1
- busy  output  1  high in every state except IDLE
- tx_done  output  1  single-cycle pulse when a frame completes

## Operation
- The FSM has six states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE
  - tx=1.
  - If tx_en=1 and fifo_empty=0, the next state is LOAD; otherwise stay in IDLE.
- LOAD, exactly one cycle
  - fifo_rd_en=1 combinationally while in LOAD.
  - At the exiting edge, capture fifo_data into an 8-bit shift register.
  - At the same edge, latch parity_en, parity_odd and stop2. They are held constant for the whole frame.
  - Clear the baud counter and bit index.
  - Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA
  - tx = shift_reg[0].
  - At each bit end, shift right and increment bit_idx (3 bits).
  - After bit_idx=7 completes: next state is PARITY if parity_en is latched, otherwise STOP.
- PARITY
  - tx = XOR of the 8 captured bits, XOR parity_odd.
  - Duration CLKS_PER_BIT cycles, then STOP.
- STOP
  - tx=1 for CLKS_PER_BIT cycles, or 2×CLKS_PER_BIT if stop2 is latched. A stop-bit counter is used for this.
  - At the end, the next state is IDLE and tx_done is registered high for that first IDLE cycle.
- Baud counter
  - Counts 0..CLKS_PER_BIT-1.
  - Bit end is when counter = CLKS_PER_BIT-1; at that point it wraps to 0.
  - It does not run in IDLE or LOAD.
- tx_en deasserted mid-frame: the current frame completes normally; no new LOAD is taken.
- fifo_empty changing mid-frame is ignored.
- Configuration input changes mid-frame have no effect until the next LOAD.
- A byte is popped only in LOAD, so exactly one fifo_rd_en pulse occurs per frame.
- Reset
  - On assertion, all outputs go to their reset values: tx=1, busy=0, fifo_rd_en=0, tx_done=0.
  - The state goes to IDLE, and all counters and the shift register are cleared.
  - A byte already popped and partially sent is discarded, not retransmitted.

## Timing
- tx, busy and tx_done are registered outputs. fifo_rd_en is a combinational decode of state==LOAD.
- The FIFO samples fifo_rd_en at the edge that exits LOAD, the same edge at which fifo_data is captured.
- Latency from fifo_empty seen low in IDLE:
  - LOAD is entered at the next edge.
  - The tx falling edge (start bit) occurs 2 edges after fifo_empty is first sampled low.
- Frame length is (1 + 8 + parity_en + 1 + stop2) × CLKS_PER_BIT cycles, measured from the tx falling edge to the cycle tx_done is high.
- Back-to-back frames have a minimum gap of 2 cycles with tx=1 between the end of STOP and the next start bit (one IDLE cycle, one LOAD cycle).
- tx_done and busy=0 coincide in the first IDLE cycle.

## Test plan
- CLKS_PER_BIT=4, no parity, 1 stop, push 0xA5:
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - One fifo_rd_en pulse.
  - tx_done one cycle, 40 cycles after the start-bit edge.
- parity_en=1, parity_odd=0, byte 0x07: parity bit = 1.
- Repeat with parity_odd=1: parity bit = 0. Frame is 44 cycles in both cases.
- stop2=1, byte 0x00: tx low for 36 cycles, then high for 8 cycles before tx_done.
- Push 0x55 and 0x0F back-to-back with tx_en=1:
  - Exactly 2 high cycles between the first frame's STOP end and the second start bit.
  - Two fifo_rd_en pulses; fifo_empty seen high after the second pop.
- Pulse rst_n low during DATA bit 3 of 0xFF:
  - tx=1 and busy=0 immediately.
  - After release, with the FIFO holding 0x3C, a new frame of 0x3C starts after 2 cycles.
- tx_en=0 with the FIFO non-empty: no fifo_rd_en and tx stays 1. Raising tx_en starts a frame 2 cycles later.
- Dropping tx_en mid-frame lets the frame finish; no new frame starts.
